qadd: RTL and testbench
=======================

QADD -- requirements
Module: qadd

Interface
REQ-001 Parameter Q, default 19: number of fractional bits in the magnitude field.
REQ-002 Parameter N, default 32: total word width; bit N-1 is the sign (1 = negative); bits N-2:0 are the unsigned magnitude with Q fractional bits.
REQ-003 Parameter legality: 1 <= Q <= N-2 and N >= 3; an elaboration-time check SHALL reject any other values.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  a and b are valid this cycle.
REQ-007 a  input  N  sign-magnitude operand A.
REQ-008 b  input  N  sign-magnitude operand B.
REQ-009 c  output  N  registered sign-magnitude sum A+B.
REQ-010 out_valid  output  1  c and ovf are valid; asserted exactly one cycle after the matching in_valid.
REQ-011 ovf  output  1  set when the magnitude of the result saturated.

Function
REQ-012 Latency SHALL be exactly 1 clock: inputs sampled with in_valid=1 at edge k appear on c, ovf and out_valid=1 after edge k.
REQ-013 With in_valid=0 at an edge, out_valid SHALL be 0 after that edge; c and ovf SHALL hold their previous values.
REQ-014 No backpressure: a new operand pair SHALL be accepted on every cycle (fully pipelined, throughput 1 per clock).
REQ-015 Same signs: result magnitude = |A|+|B| computed at N bits; result sign = common sign.
REQ-016 Same-sign carry out of bit N-2: magnitude SHALL saturate to all ones (2^(N-1)-1), sign SHALL be kept, and ovf SHALL be 1; otherwise ovf SHALL be 0.
REQ-017 Different signs: result magnitude = larger magnitude minus smaller magnitude; result sign = sign of the operand with the larger magnitude; ovf SHALL be 0.
REQ-018 Equal magnitudes with different signs: result SHALL be all zeros (positive zero).
REQ-019 Negative-zero inputs (sign=1, magnitude=0) SHALL be treated as zero; a zero-magnitude result SHALL always have its sign bit at 0.
REQ-020 Q SHALL NOT affect the arithmetic; it only defines the binary point. No rounding occurs.

Reset
REQ-021 While rst_n=0 (asynchronously): c=0, ovf=0, out_valid=0.
REQ-022 A transaction in flight when reset asserts SHALL be discarded; the first out_valid after reset release SHALL belong to an in_valid sampled after the release.

Structure
REQ-023 A shared package qadd_pkg SHALL hold the default Q/N constants and a function that builds the sign-magnitude saturation limit.
REQ-024 The combinational datapath SHALL be one sub-module, qadd_sm_core (inputs a, b; outputs sum and ovf). The top level SHALL contain only the output register stage and the valid pipeline.

Verification (Q=19, N=32; 1.0 = 0x0008_0000)
REQ-025 a=0x0008_0000 (+1.0), b=0x8004_0000 (-0.5), in_valid=1 -> next cycle c=0x0004_0000, ovf=0, out_valid=1.
REQ-026 a=0x0004_0000, b=0x8008_0000 -> c=0x8004_0000 (-0.5); and a=0x0008_0000, b=0x8008_0000 -> c=0x0000_0000.
REQ-027 a=0x8008_0000, b=0x8008_0000 -> c=0x8010_0000 (-2.0), ovf=0.
REQ-028 a=0x7FFF_FFFF, b=0x0000_0001 -> c=0x7FFF_FFFF, ovf=1; a=0xFFFF_FFFF, b=0x8000_0001 -> c=0xFFFF_FFFF, ovf=1.
REQ-029 Sweep: a magnitude steps by 5179347 up to 2.1e9 with sign 0, b magnitude steps by 3779351 with sign 1, in_valid=1 every cycle -> every output matches a behavioural sign-magnitude model one cycle later, and c is never negative zero.
REQ-030 Assert rst_n=0 mid-stream between clock edges -> c, ovf and out_valid go to 0 immediately; after release with in_valid=0, out_valid stays 0.

Source files
------------

// File: rtl/qadd_pkg.sv
// Shared constants and helpers for the sign-magnitude fixed-point adder.
// The saturation limit is built here so every user agrees on its encoding.
package qadd_pkg;

    localparam int Q_DEF = 19;
    localparam int N_DEF = 32;
    localparam int MAX_N = 256;

    // {sign, all-ones magnitude} in the low n bits; the bits above n are zero.
    function automatic logic [MAX_N-1:0] sm_sat_limit(input int n, input logic sign);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n - 1)       r[i] = 1'b1;
            else if (i == n - 1) r[i] = sign;
        end
        return r;
    endfunction

endpackage

// File: rtl/qadd_sm_core.sv
// Combinational sign-magnitude add with magnitude saturation.
// A zero-magnitude result always has its sign bit cleared.
module qadd_sm_core
    import qadd_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         ovf
);

    localparam logic [MAX_N-1:0] LIM_P = sm_sat_limit(N, 1'b0);
    localparam logic [MAX_N-1:0] LIM_N = sm_sat_limit(N, 1'b1);

    logic         sa, sb, sign;
    logic [N-2:0] ma, mb, mag;
    logic [N-1:0] add_w;

    assign sa    = a[N-1];
    assign sb    = b[N-1];
    assign ma    = a[N-2:0];
    assign mb    = b[N-2:0];
    assign add_w = {1'b0, ma} + {1'b0, mb};

    always_comb begin
        ovf  = 1'b0;
        sign = 1'b0;
        mag  = '0;
        if (sa == sb) begin
            sign = sa;
            mag  = add_w[N-2:0];
            ovf  = add_w[N-1];
        end else if (ma >= mb) begin
            sign = sa;
            mag  = ma - mb;
        end else begin
            sign = sb;
            mag  = mb - ma;
        end
        // Negative zero collapses to positive zero here, whatever the inputs were.
        if (ovf) sum = sign ? LIM_N[N-1:0] : LIM_P[N-1:0];
        else     sum = {sign & (|mag), mag};
    end

endmodule

// File: rtl/qadd.sv
// Registered sign-magnitude fixed-point adder, one-cycle latency, one op per clock.
// Holds only the output register and the valid pipeline around qadd_sm_core.
module qadd
    import qadd_pkg::*;
#(
    parameter int Q = Q_DEF,
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] c,
    output logic         out_valid,
    output logic         ovf
);

    localparam int STAGES = 1;

    if (!(N >= 3 && Q >= 1 && Q <= N - 2 && N <= MAX_N)) begin : g_bad_param
        $error("qadd: illegal parameters Q=%0d N=%0d", Q, N);
    end

    logic [N-1:0]      sum, c_d, c_q;
    logic              sum_ovf, ovf_d, ovf_q;
    logic [STAGES:1]   vld_pipe_q;
    logic [STAGES:0]   vld_pipe;

    qadd_sm_core #(.N(N)) u_core (
        .a   (a),
        .b   (b),
        .sum (sum),
        .ovf (sum_ovf)
    );

    always_comb begin
        vld_pipe = {vld_pipe_q, in_valid};
        c_d      = in_valid ? sum     : c_q;
        ovf_d    = in_valid ? sum_ovf : ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q        <= '0;
            ovf_q      <= 1'b0;
            vld_pipe_q <= '0;
        end else begin
            c_q        <= c_d;
            ovf_q      <= ovf_d;
            vld_pipe_q <= vld_pipe[STAGES-1:0];
        end
    end

    assign c         = c_q;
    assign ovf       = ovf_q;
    assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_qadd.sv
// Self-checking bench for qadd: directed cases, a magnitude sweep, random traffic
// and mid-stream reset, all checked against a signed-integer value model.
module tb_qadd;

    localparam int N = 32;
    localparam int Q = 19;
    localparam longint MAXM = (64'sd1 <<< (N - 1)) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [N-1:0] c;
    logic         out_valid;
    logic         ovf;

    qadd #(.Q(Q), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    logic [N-1:0] exp_c = '0;
    logic         exp_ovf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Value-level model: turn operands into signed integers, add, clamp.
    task automatic model(input logic [N-1:0] av, input logic [N-1:0] bv,
                         output logic [N-1:0] mc, output logic mo);
        longint va, vb, s, m;
        va = av[N-1] ? -longint'(av[N-2:0]) : longint'(av[N-2:0]);
        vb = bv[N-1] ? -longint'(bv[N-2:0]) : longint'(bv[N-2:0]);
        s  = va + vb;
        m  = (s < 0) ? -s : s;
        mo = (m > MAXM);
        if (mo) m = MAXM;
        mc = {(s < 0), m[N-2:0]};
    endtask

    task automatic step(input logic v, input logic [N-1:0] av, input logic [N-1:0] bv);
        logic [N-1:0] mc;
        logic         mo;
        @(negedge clk);
        in_valid = v;
        a        = av;
        b        = bv;
        if (v) begin
            model(av, bv, mc, mo);
            exp_c   = mc;
            exp_ovf = mo;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(v));
        chk("c", 64'(c), 64'(exp_c));
        chk("ovf", 64'(ovf), 64'(exp_ovf));
        chk("negzero", 64'(c[N-1] && (c[N-2:0] == '0)), 64'(0));
    endtask

    task automatic dir(input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic [N-1:0] ec, input logic eo);
        step(1'b1, av, bv);
        chk("dir_c", 64'(c), 64'(ec));
        chk("dir_ovf", 64'(ovf), 64'(eo));
    endtask

    function automatic logic [N-1:0] rnd_op(input int mode);
        logic [N-1:0] r;
        r = $urandom();
        case (mode)
            0: r[N-2:0] = '0;
            1: r[N-2:0] = r[N-2:0] | {(N-5){1'b1}} << 4 >> 4 | (31'h7FFF_FFF0);
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        #2;
        chk("rst_c", 64'(c), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        chk("rst_vld", 64'(out_valid), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, '0);

        dir(32'h0008_0000, 32'h8004_0000, 32'h0004_0000, 1'b0);
        dir(32'h0004_0000, 32'h8008_0000, 32'h8004_0000, 1'b0);
        dir(32'h0008_0000, 32'h8008_0000, 32'h0000_0000, 1'b0);
        dir(32'h8008_0000, 32'h8008_0000, 32'h8010_0000, 1'b0);
        dir(32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
        dir(32'hFFFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1);
        dir(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0);
        dir(32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        dir(32'h8000_0000, 32'h0000_0005, 32'h0000_0005, 1'b0);
        dir(32'h4000_0000, 32'h4000_0000, 32'h7FFF_FFFF, 1'b1);
        dir(32'h3FFF_FFFF, 32'h4000_0000, 32'h7FFF_FFFF, 1'b0);
        // Held outputs on idle cycles after an overflow.
        step(1'b0, 32'h1234_5678, 32'h0000_0001);
        step(1'b0, '0, '0);

        for (int i = 0; longint'(i) * 5179347 <= 2100000000; i++) begin
            logic [N-1:0] av, bv;
            av = {1'b0, 31'(longint'(i) * 5179347)};
            bv = {1'b1, 31'(longint'(i) * 3779351)};
            step(1'b1, av, bv);
        end

        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] av, bv;
            int ma, mb;
            ma = $urandom_range(0, 3);
            mb = $urandom_range(0, 3);
            av = rnd_op(ma);
            bv = rnd_op(mb);
            if ($urandom_range(0, 7) == 0) bv[N-2:0] = av[N-2:0];
            step(($urandom_range(0, 3) != 0), av, bv);
        end

        // Reset lands between edges while a new pair is on the inputs.
        step(1'b1, 32'h0010_0000, 32'h0001_0000);
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h0020_0000;
        b        = 32'h0002_0000;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_c", 64'(c), 64'(0));
        chk("mid_rst_ovf", 64'(ovf), 64'(0));
        chk("mid_rst_vld", 64'(out_valid), 64'(0));
        exp_c   = '0;
        exp_ovf = 1'b0;
        @(posedge clk);
        #1;
        chk("in_rst_vld", 64'(out_valid), 64'(0));
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (3) step(1'b0, 32'h0020_0000, 32'h0002_0000);
        dir(32'h0020_0000, 32'h0002_0000, 32'h0022_0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

●
